// File: rtl/game_dialog_ctrl_if.sv
// Bus between the game engine and the dialog controller: player input and
// pixel probe towards the controller, dialog/flag state back to the engine.
interface game_dialog_ctrl_if #(
    parameter int FLAG_NUM = 2
);
    logic [3:0]          key;
    logic [11:0]         current_pix;
    logic                flags_clr;
    logic                dialog_active;
    logic [2:0]          dialog_id;
    logic [3:0]          page;
    logic [FLAG_NUM-1:0] flags;
    logic                action_ok;
    logic                action_denied;

    modport master (
        output key, current_pix, flags_clr,
        input  dialog_active, dialog_id, page, flags, action_ok, action_denied
    );

    modport slave (
        input  key, current_pix, flags_clr,
        output dialog_active, dialog_id, page, flags, action_ok, action_denied
    );
endinterface

// File: rtl/game_dialog_ctrl.sv
// Dialog controller: detects which interaction zone the player stands on by
// marker colour, pages through that zone's dialog on key presses and, when
// the last page is confirmed, checks/sets game-state flags.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | player not on any zone marker
// TALK      | dialog shown, paging through the active zone
// DONE      | last page confirmed, completion result issued, window held
// DISMISSED | dialog closed by the player while still standing in the zone
module game_dialog_ctrl #(
    parameter int                      NPC_NUM    = 3,
    parameter int                      FLAG_NUM   = 2,
    parameter logic [12*NPC_NUM-1:0]   ZONE_COLOR = {12'hFF0, 12'h0FF, 12'h00F},
    parameter logic [4*NPC_NUM-1:0]    ZONE_PAGES = {4'd1, 4'd2, 4'd1},
    parameter logic [4*NPC_NUM-1:0]    ZONE_REQ   = {4'h8, 4'h0, 4'h0},
    parameter logic [4*NPC_NUM-1:0]    ZONE_SET   = {4'h9, 4'h8, 4'h0},
    parameter logic [3:0]              KEY_NEXT   = 4'h1,
    parameter logic [3:0]              KEY_EXIT   = 4'h2
) (
    input  logic             clk,
    input  logic             rst,
    game_dialog_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TALK      = 2'd1,
        DONE      = 2'd2,
        DISMISSED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          key_prev_q, key_prev_d;
    logic [2:0]          dialog_id_q, dialog_id_d;
    logic [3:0]          page_q, page_d;
    logic [FLAG_NUM-1:0] flags_q, flags_d;
    logic                dialog_active_q, dialog_active_d;
    logic                action_ok_q, action_ok_d;
    logic                action_denied_q, action_denied_d;

    logic                match_hit;
    logic [2:0]          match_id;
    logic                press_next, press_exit;
    logic [3:0]          zone_pages, zone_req, zone_set;
    logic                req_met;

    // Zone lookup by marker colour; scanning high to low lets the lowest index win.
    always_comb begin
        match_hit = 1'b0;
        match_id  = 3'd0;
        for (int i = NPC_NUM - 1; i >= 0; i--) begin
            if (bus.current_pix == ZONE_COLOR[12*i +: 12]) begin
                match_hit = 1'b1;
                match_id  = 3'(i);
            end
        end
    end

    // One press per key-down: held keys are ignored after the first cycle.
    always_comb begin
        press_next = (bus.key == KEY_NEXT) && (key_prev_q != KEY_NEXT);
        press_exit = (bus.key == KEY_EXIT) && (key_prev_q != KEY_EXIT);
    end

    // Per-zone table lookup and completion gate; flag indices beyond FLAG_NUM never match.
    always_comb begin
        zone_pages = ZONE_PAGES[4*int'(dialog_id_q) +: 4];
        zone_req   = ZONE_REQ[4*int'(dialog_id_q) +: 4];
        zone_set   = ZONE_SET[4*int'(dialog_id_q) +: 4];
        req_met    = !zone_req[3];
        for (int f = 0; f < FLAG_NUM; f++) begin
            if (zone_req[3] && (int'(zone_req[2:0]) == f) && flags_q[f]) begin
                req_met = 1'b1;
            end
        end
    end

    // Next-state logic: zone changes pre-empt (and swallow) key presses.
    always_comb begin
        state_d         = state_q;
        key_prev_d      = bus.key;
        dialog_id_d     = dialog_id_q;
        page_d          = page_q;
        flags_d         = flags_q;
        action_ok_d     = 1'b0;
        action_denied_d = 1'b0;

        if (!match_hit) begin
            state_d = IDLE;
            page_d  = 4'd0;
        end else if ((state_q == IDLE) || (match_id != dialog_id_q)) begin
            state_d     = TALK;
            dialog_id_d = match_id;
            page_d      = 4'd0;
        end else begin
            case (state_q)
                TALK: begin
                    if (press_next) begin
                        if (({1'b0, page_q} + 5'd1) < {1'b0, zone_pages}) begin
                            page_d = page_q + 4'd1;
                        end else begin
                            state_d = DONE;
                            if (req_met) begin
                                action_ok_d = 1'b1;
                                for (int f = 0; f < FLAG_NUM; f++) begin
                                    if (zone_set[3] && (int'(zone_set[2:0]) == f)) begin
                                        flags_d[f] = 1'b1;
                                    end
                                end
                            end else begin
                                action_denied_d = 1'b1;
                            end
                        end
                    end else if (press_exit) begin
                        state_d = DISMISSED;
                    end
                end
                DONE: begin
                    if (press_next || press_exit) begin
                        state_d = DISMISSED;
                    end
                end
                default: ;
            endcase
        end

        if (bus.flags_clr) begin
            flags_d = '0;
        end

        dialog_active_d = (state_d == TALK) || (state_d == DONE);
    end

    // All state and outputs registered; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            key_prev_q      <= 4'h0;
            dialog_id_q     <= 3'd0;
            page_q          <= 4'd0;
            flags_q         <= '0;
            dialog_active_q <= 1'b0;
            action_ok_q     <= 1'b0;
            action_denied_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            key_prev_q      <= key_prev_d;
            dialog_id_q     <= dialog_id_d;
            page_q          <= page_d;
            flags_q         <= flags_d;
            dialog_active_q <= dialog_active_d;
            action_ok_q     <= action_ok_d;
            action_denied_q <= action_denied_d;
        end
    end

    assign bus.dialog_active = dialog_active_q;
    assign bus.dialog_id     = dialog_id_q;
    assign bus.page          = page_q;
    assign bus.flags         = flags_q;
    assign bus.action_ok     = action_ok_q;
    assign bus.action_denied = action_denied_q;

endmodule

// File: tb/tb_game_dialog_ctrl.sv
// Bench for game_dialog_ctrl with default parameters: directed scenarios then
// random play, checked through an expected-response queue.
module tb_game_dialog_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_dialog_ctrl_if #(.FLAG_NUM(2)) bus ();

    game_dialog_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit active;
        int id;
        int page;
        int flags;
        bit ok;
        bit den;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_pop  = 0;
    int   n_push = 0;

    // Reference: zone table written straight from the default parameters.
    int colors[3] = '{'h00F, 'h0FF, 'hFF0};
    int pages[3]  = '{1, 2, 1};
    int reqs[3]   = '{0, 0, 8};
    int sets[3]   = '{0, 8, 9};

    localparam int PH_IDLE = 0, PH_TALK = 1, PH_DONE = 2, PH_DISM = 3;
    int       m_phase = PH_IDLE;
    int       m_id = 0, m_page = 0, m_prev = 0;
    bit [1:0] m_flags = 2'b00;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int zone_of(input int pix);
        for (int i = 0; i < 3; i++) if (colors[i] == pix) return i;
        return -1;
    endfunction

    // Advances the model by one clock with the given inputs, returns the expected outputs.
    function automatic exp_t model_step(input int k, input int pix, input bit clr, input bit r);
        exp_t e;
        bit pn, px;
        int z;
        e.ok = 0;
        e.den = 0;
        if (r) begin
            m_phase = PH_IDLE; m_id = 0; m_page = 0; m_prev = 0; m_flags = 0;
        end else begin
            pn = (k == 1) && (m_prev != 1);
            px = (k == 2) && (m_prev != 2);
            m_prev = k;
            z = zone_of(pix);
            if (z < 0) begin
                m_phase = PH_IDLE; m_page = 0;
            end else if (m_phase == PH_IDLE || z != m_id) begin
                m_phase = PH_TALK; m_id = z; m_page = 0;
            end else if (m_phase == PH_TALK && pn) begin
                if (m_page + 1 < pages[m_id]) m_page++;
                else begin
                    m_phase = PH_DONE;
                    if ((reqs[m_id] & 8) == 0 ||
                        ((reqs[m_id] & 7) < 2 && m_flags[reqs[m_id] & 7])) begin
                        e.ok = 1;
                        if ((sets[m_id] & 8) != 0 && (sets[m_id] & 7) < 2)
                            m_flags[sets[m_id] & 7] = 1'b1;
                    end else e.den = 1;
                end
            end else if (m_phase == PH_TALK && px) begin
                m_phase = PH_DISM;
            end else if (m_phase == PH_DONE && (pn || px)) begin
                m_phase = PH_DISM;
            end
            if (clr) m_flags = 0;
        end
        e.active = (m_phase == PH_TALK) || (m_phase == PH_DONE);
        e.id     = m_id;
        e.page   = m_page;
        e.flags  = int'(m_flags);
        return e;
    endfunction

    task automatic cyc(input logic [3:0] k, input logic [11:0] p,
                       input logic c = 1'b0, input logic r = 1'b0);
        @(negedge clk);
        bus.key         = k;
        bus.current_pix = p;
        bus.flags_clr   = c;
        rst             = r;
        exp_q.push_back(model_step(int'(k), int'(p), c, r));
        n_push++;
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle's outputs are compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pop++;
                chk("sb_active", int'(bus.dialog_active), int'(e.active));
                chk("sb_id",     int'(bus.dialog_id),     e.id);
                chk("sb_page",   int'(bus.page),          e.page);
                chk("sb_flags",  int'(bus.flags),         e.flags);
                chk("sb_ok",     int'(bus.action_ok),     int'(e.ok));
                chk("sb_denied", int'(bus.action_denied), int'(e.den));
            end
        end
    end

    initial begin
        logic [3:0]  rk;
        logic [11:0] rp;
        logic        rc, rr;
        bus.key = 4'h0;
        bus.current_pix = 12'h000;
        bus.flags_clr = 1'b0;

        cyc(0, 12'h000, 0, 1);
        cyc(0, 12'h000, 0, 1);
        peek();
        chk("reset_active", int'(bus.dialog_active), 0);
        chk("reset_flags", int'(bus.flags), 0);
        cyc(0, 12'h000);

        // Zone 0: single page, no requirement, no set.
        cyc(0, 12'h00F);
        peek();
        chk("z0_enter_active", int'(bus.dialog_active), 1);
        chk("z0_enter_page", int'(bus.page), 0);
        cyc(1, 12'h00F);
        peek();
        chk("z0_done_ok", int'(bus.action_ok), 1);
        chk("z0_done_flags", int'(bus.flags), 0);

        // Zone 2 needs flag 0, still clear.
        cyc(0, 12'hFF0);
        cyc(1, 12'hFF0);
        peek();
        chk("z2_denied", int'(bus.action_denied), 1);
        chk("z2_denied_flags", int'(bus.flags), 0);

        // Zone 1: two pages, sets flag 0.
        cyc(0, 12'h0FF);
        cyc(1, 12'h0FF);
        peek();
        chk("z1_page1", int'(bus.page), 1);
        cyc(0, 12'h0FF);
        cyc(1, 12'h0FF);
        peek();
        chk("z1_ok", int'(bus.action_ok), 1);
        chk("z1_flags", int'(bus.flags), 1);

        // Zone 2 now allowed, sets flag 1.
        cyc(0, 12'hFF0);
        cyc(1, 12'hFF0);
        peek();
        chk("z2_ok", int'(bus.action_ok), 1);
        chk("z2_flags", int'(bus.flags), 3);

        // Idempotent set of flag 0 with a same-cycle clear.
        cyc(0, 12'h0FF);
        cyc(1, 12'h0FF);
        cyc(0, 12'h0FF);
        cyc(1, 12'h0FF, 1);
        peek();
        chk("clr_vs_set_flags", int'(bus.flags), 0);
        chk("clr_vs_set_ok", int'(bus.action_ok), 1);

        // Dismiss, ignored keys, re-entry.
        cyc(0, 12'h00F);
        cyc(2, 12'h00F);
        peek();
        chk("dismiss_active", int'(bus.dialog_active), 0);
        cyc(0, 12'h00F);
        cyc(1, 12'h00F);
        peek();
        chk("dismissed_key_ignored", int'(bus.dialog_active), 0);
        cyc(0, 12'h000);
        cyc(0, 12'hFF0);
        peek();
        chk("reenter_active", int'(bus.dialog_active), 1);
        chk("reenter_id", int'(bus.dialog_id), 2);

        // Held key gives one advance; zone change swallows a press.
        cyc(0, 12'h0FF);
        repeat (20) cyc(1, 12'h0FF);
        peek();
        chk("held_key_page", int'(bus.page), 1);
        chk("held_key_no_ok", int'(bus.action_ok), 0);
        cyc(0, 12'h0FF);
        cyc(1, 12'hFF0);
        peek();
        chk("zone_change_id", int'(bus.dialog_id), 2);
        chk("zone_change_page", int'(bus.page), 0);
        chk("zone_change_no_ok", int'(bus.action_ok), 0);
        chk("zone_change_no_den", int'(bus.action_denied), 0);

        // Reset mid-dialog.
        cyc(0, 12'h0FF);
        cyc(1, 12'h0FF);
        cyc(1, 12'h0FF, 0, 1);
        peek();
        chk("midreset_active", int'(bus.dialog_active), 0);
        chk("midreset_page", int'(bus.page), 0);
        chk("midreset_flags", int'(bus.flags), 0);
        cyc(0, 12'h0FF);
        peek();
        chk("after_reset_active", int'(bus.dialog_active), 1);
        chk("after_reset_id", int'(bus.dialog_id), 1);

        // Random play.
        rk = 4'h0;
        rp = 12'h000;
        repeat (2000) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    rk = 4'h0;
                    2, 3:    rk = 4'h1;
                    4:       rk = 4'h2;
                    default: rk = 4'($urandom);
                endcase
            end
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0:       rp = 12'h000;
                    1:       rp = 12'h00F;
                    2:       rp = 12'h0FF;
                    3:       rp = 12'hFF0;
                    default: rp = 12'($urandom);
                endcase
            end
            rc = ($urandom_range(0, 29) == 0);
            rr = ($urandom_range(0, 199) == 0);
            cyc(rk, rp, rc, rr);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("pop_count", n_pop, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/game_dialog_ctrl.md
GAME_DIALOG_CTRL -- requirements
Module: game_dialog_ctrl

Interface
REQ-001 SHALL have parameter NPC_NUM, default 3, meaning the number of interaction zones (1..8).
REQ-002 SHALL have parameter FLAG_NUM, default 2, meaning the number of game-state flags (1..8).
REQ-003 SHALL have parameter ZONE_COLOR, default {12'hFF0,12'h0FF,12'h00F}, meaning the packed zone-i marker colour in bits [12i+11:12i].
REQ-004 SHALL have parameter ZONE_PAGES, default {4'd1,4'd2,4'd1}, meaning the packed dialog page count of zone i (1..15).
REQ-005 SHALL have parameter ZONE_REQ, default {4'h8,4'h0,4'h0}, meaning the packed per-zone required flag: bit3 = required, bits[2:0] = flag index.
REQ-006 SHALL have parameter ZONE_SET, default {4'h9,4'h8,4'h0}, meaning the packed per-zone flag set on completion: bit3 = set enabled, bits[2:0] = flag index.
REQ-007 SHALL have parameters KEY_NEXT, default 4'h1, meaning advance/confirm, and KEY_EXIT, default 4'h2, meaning dismiss; 4'h0 means no key.
REQ-008 clk  in  1  system clock.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 key  in  4  current key code, level.
REQ-011 current_pix  in  12  colour under player position.
REQ-012 flags_clr  in  1  synchronous clear of all flags.
REQ-013 dialog_active  out  1  dialog window shall be drawn.
REQ-014 dialog_id  out  3  active zone index.
REQ-015 page  out  4  active page within zone.
REQ-016 flags  out  FLAG_NUM  game-state flags.
REQ-017 action_ok  out  1  one-cycle pulse, completion accepted.
REQ-018 action_denied  out  1  one-cycle pulse, completion refused (required flag clear).

Function
REQ-019 Zone match SHALL be combinational: current_pix == ZONE_COLOR[i]; lowest i wins on multiple matches; no match = "none".
REQ-020 Key press SHALL be edge-detected: press_X = (key==X) && (key_prev!=X); key_prev is registered, reset 4'h0.
REQ-021 All outputs SHALL be registered; each reflects inputs sampled one clk earlier.
REQ-022 FSM states SHALL be IDLE, TALK, DONE, DISMISSED; dialog_active = 1 only in TALK or DONE.
REQ-023 IDLE: on match -> TALK, dialog_id = match, page = 0.
REQ-024 TALK: press_NEXT with page < ZONE_PAGES-1 -> page+1; press_NEXT on last page -> DONE and completion check (REQ-027); press_EXIT -> DISMISSED.
REQ-025 DONE: page is held; press_NEXT or press_EXIT -> DISMISSED.
REQ-026 In any state: no match -> IDLE with page = 0; match != dialog_id -> TALK with the new id and page = 0. Zone change SHALL take priority over a simultaneous key press, and that press SHALL be discarded.
REQ-027 Completion: if ZONE_REQ bit3 = 0 or flags[req] = 1, action_ok pulses and flags[set] <= 1 when ZONE_SET bit3 = 1; otherwise action_denied pulses and flags are unchanged.
REQ-028 Setting an already-set flag SHALL be idempotent and still pulse action_ok.
REQ-029 flags_clr SHALL zero all flags next cycle and SHALL take priority over a same-cycle set; the FSM is unaffected.
REQ-030 Simultaneous press_NEXT and press_EXIT are impossible (single key bus); a key held for many cycles SHALL produce exactly one press.
REQ-031 Index fields >= FLAG_NUM SHALL be ignored: no set occurs, and a requirement on such an index is treated as unsatisfied.

Reset
REQ-032 On rst, state = IDLE, and dialog_id, page, flags, action_ok, action_denied and key_prev SHALL all be 0.
REQ-033 Reset mid-dialog SHALL abort without any flag change; after release, a still-matching zone re-enters TALK at page 0.

Verification
REQ-034 Defaults: current_pix = 00F, then key 1 -> active = 1, id = 0, page = 0; next cycle DONE, action_ok pulse, flags = 00.
REQ-035 current_pix = FF0, key 1 -> action_denied pulse, flags = 00; then current_pix = 0FF, key 1 twice -> page 0->1, then action_ok, flags = 01.
REQ-036 With flags = 01: current_pix = FF0, key 1 -> action_ok, flags = 11; flags_clr in the same cycle as a set -> flags = 00.
REQ-037 In TALK, key 2 -> DISMISSED, active = 0; key 1 ignored; current_pix -> 000 then FF0 -> active = 1, page = 0.
REQ-038 key = 1 held 20 cycles in zone 1 -> exactly one page advance; a zone change in the same cycle as a key press -> new id, page 0, no advance.
REQ-039 rst asserted in zone 1, page 1 -> all outputs 0 next cycle, flags unchanged from 0.
